// File: rtl/if_id_buffer_pkg.sv
// ifid_pkg: shared constants, the fetch/decode entry type and the saturating
// add helper used by the optional drop counter (IFID_PERF_EN).
package ifid_pkg;

  // addi x0,x0,0 -- shown on the decode side whenever the buffer is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch result on a 32-bit core
  typedef struct packed {
    logic [31:0] Instr;
    logic [31:0] PCPlus4;
  } ifid_entry_t;

  // 16-bit add that clamps at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] n);
    logic [16:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, n};
    if (sum_s[16]) begin
      return 16'hFFFF;
    end else begin
      return sum_s[15:0];
    end
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: fetch-side valid/ready and decode-side stall/flush bundle.
// master = pipeline side (fetch + decode stages), slave = the buffer.
interface if_id_buffer_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCPlus4F;
  logic            ValidF;
  logic            ReadyF;
  logic            StallD;
  logic            FlushD;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;

  modport master (
    output InstrF, PCPlus4F, ValidF, StallD, FlushD,
    input  ReadyF, InstrD, PCPlus4D, ValidD
  );

  modport slave (
    input  InstrF, PCPlus4F, ValidF, StallD, FlushD,
    output ReadyF, InstrD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/if_id_buffer_sat_cnt.sv
// ifid_sat_cnt: 16-bit counter that adds a variable amount per enabled cycle,
// clamps at 16'hFFFF and has a synchronous clear with priority over the add.
module ifid_sat_cnt
  import ifid_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        add_en,
  input  logic [15:0] add_n,
  output logic [15:0] cnt
);

  logic [15:0] cnt_r;

  // Clear wins; otherwise accumulate with saturation
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= 16'h0000;
    end else if (add_en) begin
      cnt_r <= sat_add16(cnt_r, add_n);
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: DEPTH-entry circular queue between fetch and decode.
// Fetch pushes with ValidF/ReadyF, decode pops the head unless StallD,
// FlushD empties the queue. Defining IFID_PERF_EN adds the DropCnt port
// counting entries discarded by flushes.
module if_id_buffer
  import ifid_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(ifid_pkg::NOP_INSTR)
) (
  input  logic        clk,
  input  logic        rst,
  if_id_buffer_if.slave bus
`ifdef IFID_PERF_EN
  ,
  output logic [15:0] DropCnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  logic [XLEN-1:0] instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [PW-1:0]   rdptr_r;
  logic [PW-1:0]   wrptr_r;
  logic [CW-1:0]   count_r;

  logic ready_s;
  logic valid_s;
  logic push_s;
  logic pop_s;

  // Pointer increment with wrap from the last entry back to zero
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Status and handshake qualifiers; ready/valid come only from count_r
  always_comb begin
    ready_s = (count_r != CNT_FULL);
    valid_s = (count_r != CNT_ZERO);
    push_s  = bus.ValidF & ready_s;
    pop_s   = valid_s & ~bus.StallD;
  end

  // Pointer and occupancy state: reset, then flush, then push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rdptr_r <= PTR_ZERO;
      wrptr_r <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (bus.FlushD) begin
      rdptr_r <= PTR_ZERO;
      wrptr_r <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wrptr_r <= ptr_inc(wrptr_r);
      end
      if (pop_s) begin
        rdptr_r <= ptr_inc(rdptr_r);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here
  always_ff @(posedge clk) begin
    if (push_s && !rst && !bus.FlushD) begin
      instr_mem_r[wrptr_r] <= bus.InstrF;
      pc_mem_r[wrptr_r]    <= bus.PCPlus4F;
    end
  end

  // Decode-side view of the head entry, NOP/zero while empty
  always_comb begin
    if (valid_s) begin
      bus.InstrD   = instr_mem_r[rdptr_r];
      bus.PCPlus4D = pc_mem_r[rdptr_r];
    end else begin
      bus.InstrD   = NOP_INSTR;
      bus.PCPlus4D = {XLEN{1'b0}};
    end
  end

  assign bus.ValidD = valid_s;
  assign bus.ReadyF = ready_s;

`ifdef IFID_PERF_EN
  logic [15:0] drop_n_s;

  // Entries lost on a flush: everything held plus an accepted same-cycle push
  always_comb begin
    drop_n_s = 16'(count_r) + 16'(push_s);
  end

  ifid_sat_cnt u_drop_cnt (
    .clk    (clk),
    .clr    (rst),
    .add_en (bus.FlushD),
    .add_n  (drop_n_s),
    .cnt    (DropCnt)
  );
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: drives a DEPTH=2 and a DEPTH=3 buffer with identical
// stimulus and compares both against queue-based reference models.
module tb_if_id_buffer;
  import ifid_pkg::*;

  typedef ifid_entry_t ent_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic        valid_f;
  logic        stall_d;
  logic        flush_d;

  int errors = 0;
  int checks = 0;

  ent_q_t q2;
  ent_q_t q3;
  int     drop2 = 0;
  int     drop3 = 0;

  if_id_buffer_if #(.XLEN(32)) ifc2 ();
  if_id_buffer_if #(.XLEN(32)) ifc3 ();

  assign ifc2.InstrF = instr_f;  assign ifc3.InstrF = instr_f;
  assign ifc2.PCPlus4F = pc_f;   assign ifc3.PCPlus4F = pc_f;
  assign ifc2.ValidF = valid_f;  assign ifc3.ValidF = valid_f;
  assign ifc2.StallD = stall_d;  assign ifc3.StallD = stall_d;
  assign ifc2.FlushD = flush_d;  assign ifc3.FlushD = flush_d;

`ifdef IFID_PERF_EN
  wire [15:0] drop_cnt2;
  wire [15:0] drop_cnt3;
  if_id_buffer #(.XLEN(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2), .DropCnt(drop_cnt2));
  if_id_buffer #(.XLEN(32), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(ifc3), .DropCnt(drop_cnt3));
`else
  if_id_buffer #(.XLEN(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));
  if_id_buffer #(.XLEN(32), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(ifc3));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a plain FIFO of entries with the rst > flush > push/pop rules
  task automatic model_edge(input int depth, inout ent_q_t q, inout int drop);
    bit push;
    bit pop;
    ifid_entry_t e;
    push = valid_f && (q.size() != depth);
    pop  = (q.size() != 0) && !stall_d;
    if (rst) begin
      q.delete();
      drop = 0;
    end else if (flush_d) begin
      drop = drop + q.size() + int'(push);
      if (drop > 65535) drop = 65535;
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.Instr = instr_f;
        e.PCPlus4 = pc_f;
        q.push_back(e);
      end
    end
  endtask

  function automatic logic [31:0] m_instr(input ent_q_t q);
    if (q.size() == 0) return 32'h0000_0013;
    return q[0].Instr;
  endfunction

  function automatic logic [31:0] m_pc(input ent_q_t q);
    if (q.size() == 0) return 32'h0000_0000;
    return q[0].PCPlus4;
  endfunction

  // One rising edge: models advance with the inputs the DUT saw, then settle
  task automatic tick();
    @(posedge clk);
    model_edge(2, q2, drop2);
    model_edge(3, q3, drop3);
    #1;
  endtask

  task automatic idle_inputs();
    valid_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; rst = 1'b0;
    instr_f = 32'h0; pc_f = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (ifc2.ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc2.ValidD); end
    checks++; if (ifc2.InstrD !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", ifc2.InstrD); end
    checks++; if (ifc2.PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", ifc2.PCPlus4D); end
    checks++; if (ifc2.ReadyF !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ifc2.ReadyF); end
    checks++; if (ifc3.ValidD !== 1'b0 || ifc3.ReadyF !== 1'b1) begin errors++; $display("FAIL reset_d3: got v=%b r=%b want v=0 r=1", ifc3.ValidD, ifc3.ReadyF); end
`ifdef IFID_PERF_EN
    checks++; if (drop_cnt2 !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt2); end
`endif
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ifc2.ReadyF !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, ifc2.ReadyF); end
      valid_f = 1'b1; stall_d = 1'b0;
      instr_f = 32'hA + 32'(i); pc_f = 32'h4 * 32'(i + 1);
      tick();
      checks++;
      if (ifc2.ValidD !== 1'b1 || ifc2.InstrD !== 32'hA + 32'(i) || ifc2.PCPlus4D !== 32'h4 * 32'(i + 1)) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b i=%h p=%h want v=1 i=%h p=%h", i, ifc2.ValidD, ifc2.InstrD, ifc2.PCPlus4D, 32'hA + 32'(i), 32'h4 * 32'(i + 1));
      end
    end
    valid_f = 1'b0;
    tick();
    checks++; if (ifc2.ValidD !== 1'b0) begin errors++; $display("FAIL stream_drain: got v=%b want 0", ifc2.ValidD); end
  endtask

  task automatic test_stall_fill();
    logic [31:0] ins [3];
    for (int i = 0; i < 3; i++) begin
      ins[i] = $urandom;
      checks++;
      if (ifc2.ReadyF !== (i < 2)) begin errors++; $display("FAIL fill_ready[%0d]: got %b want %b", i, ifc2.ReadyF, (i < 2)); end
      valid_f = 1'b1; stall_d = 1'b1; instr_f = ins[i]; pc_f = 32'h100 + 32'(4 * i);
      tick();
    end
    valid_f = 1'b0;
    checks++; if (ifc2.InstrD !== ins[0] || ifc2.ReadyF !== 1'b0) begin errors++; $display("FAIL fill_head: got i=%h r=%b want i=%h r=0", ifc2.InstrD, ifc2.ReadyF, ins[0]); end
    stall_d = 1'b0;
    tick();
    checks++; if (ifc2.InstrD !== ins[1] || ifc2.ReadyF !== 1'b1) begin errors++; $display("FAIL fill_pop1: got i=%h r=%b want i=%h r=1", ifc2.InstrD, ifc2.ReadyF, ins[1]); end
    checks++; if (ifc3.InstrD !== m_instr(q3)) begin errors++; $display("FAIL fill_d3: got %h want %h", ifc3.InstrD, m_instr(q3)); end
    tick(); tick();
    checks++; if (ifc2.ValidD !== 1'b0 || ifc3.ValidD !== 1'b0) begin errors++; $display("FAIL fill_empty: got v2=%b v3=%b want 0 0", ifc2.ValidD, ifc3.ValidD); end
  endtask

  task automatic test_flush();
    for (int rep = 0; rep < 2; rep++) begin
      int held;
      int d2_before;
      held = 2 - rep;
      d2_before = drop2;
      for (int i = 0; i < held; i++) begin
        valid_f = 1'b1; stall_d = 1'b1; instr_f = $urandom; pc_f = $urandom;
        tick();
      end
      flush_d = 1'b1; valid_f = 1'b1; instr_f = 32'hDEAD_BEEF;
      tick();
      flush_d = 1'b0; valid_f = 1'b0; stall_d = 1'b0;
      checks++; if (ifc2.ValidD !== 1'b0 || ifc2.ReadyF !== 1'b1) begin errors++; $display("FAIL flush%0d_state: got v=%b r=%b want v=0 r=1", rep, ifc2.ValidD, ifc2.ReadyF); end
      checks++; if (drop2 - d2_before != 2) begin errors++; $display("FAIL flush%0d_model: got delta %0d want 2", rep, drop2 - d2_before); end
`ifdef IFID_PERF_EN
      checks++; if (drop_cnt2 !== 16'(drop2)) begin errors++; $display("FAIL flush%0d_drop2: got %0d want %0d", rep, drop_cnt2, drop2); end
      checks++; if (drop_cnt3 !== 16'(drop3)) begin errors++; $display("FAIL flush%0d_drop3: got %0d want %0d", rep, drop_cnt3, drop3); end
`endif
      tick();
      checks++; if (ifc3.ValidD !== 1'b0) begin errors++; $display("FAIL flush%0d_d3: got v=%b want 0", rep, ifc3.ValidD); end
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 60; c++) begin
      valid_f = 1'($urandom_range(0, 3) != 0);
      stall_d = 1'($urandom_range(0, 2) == 0);
      flush_d = 1'($urandom_range(0, 19) == 0);
      instr_f = $urandom; pc_f = $urandom;
      tick();
      checks++;
      if (ifc2.ValidD !== (q2.size() != 0) || ifc2.ReadyF !== (q2.size() != 2) ||
          ifc2.InstrD !== m_instr(q2) || ifc2.PCPlus4D !== m_pc(q2)) begin
        errors++;
        $display("FAIL wrap_d2[%0d]: got v=%b r=%b i=%h p=%h want v=%b r=%b i=%h p=%h", c,
                 ifc2.ValidD, ifc2.ReadyF, ifc2.InstrD, ifc2.PCPlus4D,
                 (q2.size() != 0), (q2.size() != 2), m_instr(q2), m_pc(q2));
      end
      checks++;
      if (ifc3.ValidD !== (q3.size() != 0) || ifc3.ReadyF !== (q3.size() != 3) ||
          ifc3.InstrD !== m_instr(q3) || ifc3.PCPlus4D !== m_pc(q3)) begin
        errors++;
        $display("FAIL wrap_d3[%0d]: got v=%b r=%b i=%h p=%h want v=%b r=%b i=%h p=%h", c,
                 ifc3.ValidD, ifc3.ReadyF, ifc3.InstrD, ifc3.PCPlus4D,
                 (q3.size() != 0), (q3.size() != 3), m_instr(q3), m_pc(q3));
      end
    end
`ifdef IFID_PERF_EN
    checks++; if (drop_cnt3 !== 16'(drop3)) begin errors++; $display("FAIL wrap_drop3: got %0d want %0d", drop_cnt3, drop3); end
`endif
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      valid_f = 1'b1; stall_d = 1'b1; instr_f = $urandom; pc_f = $urandom;
      tick();
    end
    valid_f = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ifc2.ValidD !== 1'b0 || ifc2.ReadyF !== 1'b1 || ifc2.InstrD !== 32'h0000_0013) begin errors++; $display("FAIL rstmid_state: got v=%b r=%b i=%h want v=0 r=1 i=00000013", ifc2.ValidD, ifc2.ReadyF, ifc2.InstrD); end
`ifdef IFID_PERF_EN
    checks++; if (drop_cnt2 !== 16'd0) begin errors++; $display("FAIL rstmid_drop: got %0d want 0", drop_cnt2); end
`endif
    stall_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_f = 1'b1; instr_f = 32'h5000 + 32'(i); pc_f = 32'h40 + 32'(4 * i);
      tick();
      checks++;
      if (ifc2.InstrD !== 32'h5000 + 32'(i) || ifc2.PCPlus4D !== m_pc(q2)) begin
        errors++; $display("FAIL rstmid_order[%0d]: got i=%h p=%h want i=%h p=%h", i, ifc2.InstrD, ifc2.PCPlus4D, 32'h5000 + 32'(i), m_pc(q2));
      end
    end
    valid_f = 1'b0;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_stream();
    test_stall_fill();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
